// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a contiguous (optionally wrapping) range of
// register-file addresses through one read port and streams each word out
// on a valid/ready interface with its index and a last-word flag.
//
// Ports:
//   Clk, Clr           clock, synchronous active-high reset
//   Start              one-cycle dump request, honoured only when idle
//   FirstAddr/LastAddr inclusive address range, wraps 31 -> 0
//   RS / dataRS        register-file read address / combinational read data
//   DumpData/DumpIdx   streamed word and its register index
//   DumpValid/DumpReady/DumpLast  output handshake and final-word flag
//   Busy               high while fetching or sending
//   Done               one-cycle pulse after the final word is accepted
module regfile_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                        Clk,
    input  logic                        Clr,
    input  logic                        Start,
    input  logic [$clog2(NUM_REGS)-1:0] FirstAddr,
    input  logic [$clog2(NUM_REGS)-1:0] LastAddr,
    output logic [$clog2(NUM_REGS)-1:0] RS,
    input  logic [DATA_W-1:0]           dataRS,
    output logic [DATA_W-1:0]           DumpData,
    output logic [$clog2(NUM_REGS)-1:0] DumpIdx,
    output logic                        DumpValid,
    input  logic                        DumpReady,
    output logic                        DumpLast,
    output logic                        Busy,
    output logic                        Done
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);
    // Remaining count spans 1..NUM_REGS, so it needs one extra bit.
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [CNT_W-1:0]    rem_q,   rem_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [ADDR_W-1:0]   idx_q,   idx_d;
    logic                valid_q, valid_d;
    logic                last_q,  last_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;

    // Next-state and output computation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    addr_d  = FirstAddr;
                    rem_d   = CNT_W'(ADDR_W'(LastAddr - FirstAddr)) + CNT_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                data_d  = dataRS;
                idx_d   = addr_q;
                valid_d = 1'b1;
                last_d  = (rem_q == CNT_W'(1));
                addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
                rem_d   = CNT_W'(rem_q - CNT_W'(1));
                state_d = S_SEND;
            end
            S_SEND: begin
                // addr_q already points at the next word, so an accept can
                // capture it on the same edge for one word per cycle.
                if (valid_q && DumpReady) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        data_d  = dataRS;
                        idx_d   = addr_q;
                        last_d  = (rem_q == CNT_W'(1));
                        addr_d  = ADDR_W'(addr_q + ADDR_W'(1));
                        rem_d   = CNT_W'(rem_q - CNT_W'(1));
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_SEND);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset wins over everything else.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RS        = addr_q;
    assign DumpData  = data_q;
    assign DumpIdx   = idx_q;
    assign DumpValid = valid_q;
    assign DumpLast  = last_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule
